// File: rtl/pico_io_pkg.sv
// Shared constants and bus type for the picoMIPS board I/O path.
// The switch bus layout is fixed by the CPU's SW port.
package pico_io_pkg;

    localparam int SW_WIDTH  = 10;
    localparam int DATA_BITS = 8;
    localparam int STEP_BIT  = 8;
    localparam int RUN_BIT   = 9;

    typedef logic [SW_WIDTH-1:0] sw_bus_t;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter,
// accepted level and registered edge pulses.
module debounce_bit #(
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = $clog2(DB_CYCLES+1)
) (
    input  logic Clock,
    input  logic Reset,
    input  logic raw,
    output logic clean,
    output logic clean_nxt,
    output logic rise,
    output logic fall
);

    logic             s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             rise_q, fall_q;

    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (s2_q == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DB_CYCLES-1)) begin
            clean_d = s2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pulses are set on the same edge the accepted level changes.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= clean_d & ~clean_q;
            fall_q  <= ~clean_d & clean_q;
        end
    end

    assign clean     = clean_q;
    assign clean_nxt = clean_d;
    assign rise      = rise_q;
    assign fall      = fall_q;

endmodule

// File: rtl/sw_conditioner.sv
// Board switch conditioner feeding the picoMIPS SW bus: debounced
// run/step levels plus a data byte frozen on each step press.
module sw_conditioner
    import pico_io_pkg::*;
#(
    parameter int WIDTH      = SW_WIDTH,
    parameter int DB_CYCLES  = 50000,
    parameter int CNT_W      = $clog2(DB_CYCLES+1),
    parameter bit LATCH_DATA = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] SW,
    output logic             sw8_press,
    output logic             sw8_release
);

    logic [WIDTH-1:0]     clean, clean_nxt, rise, fall;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 press_nxt;
    logic                 unused_bits;

    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        debounce_bit #(
            .DB_CYCLES(DB_CYCLES),
            .CNT_W    (CNT_W)
        ) u_db (
            .Clock    (Clock),
            .Reset    (Reset),
            .raw      (sw_raw[i]),
            .clean    (clean[i]),
            .clean_nxt(clean_nxt[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

    // Capture next-state data so a bit accepted on the press edge is seen.
    assign press_nxt = clean_nxt[STEP_BIT] & ~clean[STEP_BIT];

    always_comb begin
        data_d = data_q;
        if (press_nxt) begin
            data_d = clean_nxt[DATA_BITS-1:0];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign SW[WIDTH-1:DATA_BITS] = clean[WIDTH-1:DATA_BITS];
    assign SW[DATA_BITS-1:0]     = LATCH_DATA ? data_q
                                              : clean[DATA_BITS-1:0];

    assign sw8_press   = rise[STEP_BIT];
    assign sw8_release = fall[STEP_BIT];

    assign unused_bits = ^{rise, fall, clean_nxt};

endmodule

// File: tb/tb_sw_conditioner.sv
// Directed bench for sw_conditioner at DB_CYCLES=4, latched and live data.
// Press/release pulses are checked against a queue of expected SW values.
module tb_sw_conditioner;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [9:0] sw_raw = '0;
    logic [9:0] SW, SW0;
    logic       press, release_p, press0, release0;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       rel;
        logic [9:0] sw;
    } ev_t;

    ev_t exp_q[$];

    sw_conditioner #(.DB_CYCLES(4), .LATCH_DATA(1'b1)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .sw_raw     (sw_raw),
        .SW         (SW),
        .sw8_press  (press),
        .sw8_release(release_p)
    );

    sw_conditioner #(.DB_CYCLES(4), .LATCH_DATA(1'b0)) dut0 (
        .Clock      (Clock),
        .Reset      (Reset),
        .sw_raw     (sw_raw),
        .SW         (SW0),
        .sw8_press  (press0),
        .sw8_release(release0)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [10:0] obs,
                       input logic [10:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // Scoreboard: every pulse pops one expected event.
    always @(negedge Clock) begin
        if (press || release_p) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {release_p, SW}, 11'h7FF);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("pulse_event", {release_p, SW}, {e.rel, e.sw});
            end
            chk("pulse_exclusive", {10'd0, press & release_p}, 11'd0);
        end
    end

    initial begin
        // Reset held with all switches high
        sw_raw = 10'h3FF;
        Reset  = 1'b1;
        tick(3);
        chk("reset_sw", {1'b0, SW}, 11'h000);
        chk("reset_sw0", {1'b0, SW0}, 11'h000);
        chk("reset_pulses", {9'd0, press, release_p}, 11'd0);
        Reset = 1'b0;
        exp_q.push_back('{rel: 1'b0, sw: 10'h3FF});
        tick(5);
        chk("rst_lat_before", {1'b0, SW}, 11'h000);
        tick(1);
        chk("rst_lat_sw", {press, SW}, {1'b1, 10'h3FF});
        chk("rst_lat_sw0", {press0, SW0}, {1'b1, 10'h3FF});
        tick(1);
        chk("rst_press_drop", {10'd0, press}, 11'd0);

        // All low: run and step fall together, latched data stays
        sw_raw = 10'h000;
        exp_q.push_back('{rel: 1'b1, sw: 10'h0FF});
        tick(6);
        chk("all_low_sw", {release_p, SW}, {1'b1, 10'h0FF});
        chk("all_low_sw0", {release0, SW0}, {1'b1, 10'h000});
        tick(1);

        // Bounce rejection on bit 8 with run high
        sw_raw = 10'h200;
        tick(7);
        chk("run_high", {1'b0, SW}, 11'h2FF);
        for (int r = 0; r < 5; r++) begin
            sw_raw[8] = 1'b1;
            tick(3);
            sw_raw[8] = 1'b0;
            tick(1);
            chk("bounce_sw8", {press, SW[8]}, 11'd0);
        end
        tick(8);
        chk("bounce_settled", {press, SW}, {1'b0, 10'h2FF});

        // Step latch
        sw_raw[7:0] = 8'hA5;
        tick(7);
        chk("data_held", {1'b0, SW}, 11'h2FF);
        chk("data_live0", {1'b0, SW0}, 11'h2A5);
        sw_raw[8] = 1'b1;
        exp_q.push_back('{rel: 1'b0, sw: 10'h3A5});
        tick(5);
        chk("step_before", {press, SW[8]}, 11'd0);
        tick(1);
        chk("step_press", {press, SW}, {1'b1, 10'h3A5});
        tick(1);
        chk("step_press_drop", {press, SW}, {1'b0, 10'h3A5});
        sw_raw[7:0] = 8'h3C;
        tick(8);
        chk("data_frozen", {1'b0, SW}, 11'h3A5);
        chk("data_live0b", {1'b0, SW0}, 11'h33C);

        // Release keeps latched data
        sw_raw[8] = 1'b0;
        exp_q.push_back('{rel: 1'b1, sw: 10'h2A5});
        tick(5);
        chk("rel_before", {9'd0, release_p, SW[8]}, 11'd1);
        tick(1);
        chk("rel_pulse", {release_p, SW}, {1'b1, 10'h2A5});
        chk("rel_pulse0", {release0, SW0}, {1'b1, 10'h23C});
        tick(1);
        chk("rel_drop", {release_p, SW}, {1'b0, 10'h2A5});

        // Data and step rise in the same cycle
        sw_raw = {2'b11, 8'h0F};
        exp_q.push_back('{rel: 1'b0, sw: 10'h30F});
        tick(5);
        chk("simul_before", {1'b0, SW}, 11'h2A5);
        tick(1);
        chk("simul_press", {press, SW}, {1'b1, 10'h30F});
        tick(1);
        sw_raw[8] = 1'b0;
        exp_q.push_back('{rel: 1'b1, sw: 10'h20F});
        tick(7);

        // Reset mid-debounce on the run bit
        sw_raw = 10'h000;
        tick(8);
        chk("run_low", {1'b0, SW}, 11'h00F);
        sw_raw = 10'h200;
        tick(5);
        chk("mid_before_rst", {1'b0, SW}, 11'h00F);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        chk("mid_rst_clear", {1'b0, SW}, 11'h000);
        tick(5);
        chk("mid_rst_wait", {1'b0, SW}, 11'h000);
        tick(1);
        chk("mid_rst_accept", {1'b0, SW}, 11'h200);
        chk("mid_rst_accept0", {1'b0, SW0}, 11'h200);
        tick(2);

        chk("queue_empty", 11'(exp_q.size()), 11'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
